// File: rtl/seq_detection_pkg.sv
// rtl/seq_detection_pkg.sv - shared constants and types for the serial pattern detector
package seq_detection_pkg;

    localparam int PAT_W = 4;
    localparam int DEPTH = 8;

    typedef logic [PAT_W-1:0]             pat_t;
    typedef logic [$clog2(DEPTH+1)-1:0]   cnt_t;

endpackage

// File: rtl/seq_strobe_edge.sv
// rtl/seq_strobe_edge.sv - registered rising-edge detector producing a one-cycle pulse
module seq_strobe_edge (
    input  logic clk,
    input  logic resetn,
    input  logic strobe,
    output logic rise
);

    logic strobe_q;

    // The delayed copy follows the level even in reset, so a strobe held
    // high across reset release is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        strobe_q <= strobe;
    end

    assign rise = resetn & strobe & ~strobe_q;

endmodule

// File: rtl/seq_detection.sv
// rtl/seq_detection.sv - 8-entry serial session recorder flagging 4-bit pattern matches
module seq_detection
    import seq_detection_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             p0,
    input  logic             p1,
    input  logic [PAT_W-1:0] b,
    output logic [DEPTH-1:0] o
);

    logic rise0;
    logic rise1;
    pat_t hist;
    pat_t new_hist;
    cnt_t cnt;
    logic take;
    logic hit;
    logic [DEPTH-1:0] o_set;

    seq_strobe_edge u_edge0 (
        .clk    (clk),
        .resetn (reset_n),
        .strobe (p0),
        .rise   (rise0)
    );

    seq_strobe_edge u_edge1 (
        .clk    (clk),
        .resetn (reset_n),
        .strobe (p1),
        .rise   (rise1)
    );

    // Simultaneous edges cancel; a full session ignores further entries.
    assign take     = (rise0 ^ rise1) && (cnt < cnt_t'(DEPTH));
    assign new_hist = {hist[PAT_W-2:0], rise1};
    assign hit      = take && (cnt >= cnt_t'(PAT_W-1)) && (new_hist == b);

    always_comb begin
        o_set = '0;
        for (int k = 0; k < DEPTH; k++) begin
            o_set[k] = hit && (cnt == cnt_t'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist <= '0;
            cnt  <= '0;
            o    <= '0;
        end else if (take) begin
            hist <= new_hist;
            cnt  <= cnt + cnt_t'(1);
            o    <= o | o_set;
        end
    end

endmodule

// File: tb/tb_seq_detection.sv
// tb/tb_seq_detection.sv - randomized and directed self-checking bench for seq_detection
module tb_seq_detection;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       p0;
    logic       p1;
    logic [3:0] b;
    logic [7:0] o;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    seq_detection dut (
        .clk     (clk),
        .reset_n (reset_n),
        .p0      (p0),
        .p1      (p1),
        .b       (b),
        .o       (o)
    );

    always #5 clk = ~clk;

    // Reference: list of entered bits; flags derived from the last four entries.
    bit         bits[$];
    logic [7:0] exp_o;
    logic       lvl0;
    logic       lvl1;
    logic       r0;
    logic       r1;
    int         k;
    logic [3:0] w;

    always @(posedge clk) begin
        if (!reset_n) begin
            bits.delete();
            exp_o = 8'h00;
        end else begin
            r0 = p0 && !lvl0;
            r1 = p1 && !lvl1;
            if ((r0 != r1) && (bits.size() < 8)) begin
                bits.push_back(r1);
                k = bits.size();
                if (k >= 4) begin
                    w = {bits[k-4], bits[k-3], bits[k-2], bits[k-1]};
                    if (w == b) exp_o[k-1] = 1'b1;
                end
            end
        end
        lvl0 = p0;
        lvl1 = p1;
        started = 1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (started) check("o_vs_model", o, exp_o);
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        p0 = 1'b0;
        p1 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic enter(input bit v, input int hold);
        @(negedge clk);
        if (v) p1 = 1'b1; else p0 = 1'b1;
        repeat (hold) @(negedge clk);
        p0 = 1'b0;
        p1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter_seq(input logic [7:0] s, input int n);
        for (int i = n - 1; i >= 0; i--) enter(s[i], 1);
    endtask

    task automatic pin(input string name, input logic [7:0] req);
        check({name, "_model"}, exp_o, req);
        check({name, "_dut"}, o, req);
    endtask

    task automatic pin_count(input string name, input int req);
        check(name, 8'(bits.size()), 8'(req));
    endtask

    initial begin
        reset_n = 1'b0;
        p0 = 1'b0;
        p1 = 1'b0;
        b  = 4'b0110;
        lvl0 = 1'b0;
        lvl1 = 1'b0;
        exp_o = 8'h00;

        do_reset();
        pin("reset_state", 8'h00);

        b = 4'b0110;
        enter_seq(8'b1011_0110, 8);
        pin("b0110", 8'b1001_0000);

        do_reset();
        b = 4'b0011;
        enter_seq(8'b1011_0110, 8);
        pin("b0011", 8'b0000_0000);

        do_reset();
        b = 4'b1011;
        enter_seq(8'b1011_0110, 8);
        pin("b1011", 8'b0100_1000);
        enter(1'b1, 1);
        pin("ninth_entry", 8'b0100_1000);
        pin_count("full_count", 8);

        do_reset();
        b = 4'b0110;
        enter_seq(8'b0000_0001, 2);
        @(negedge clk);
        p0 = 1'b1;
        p1 = 1'b1;
        @(negedge clk);
        p0 = 1'b0;
        p1 = 1'b0;
        @(negedge clk);
        pin_count("simul_edges", 2);
        pin("simul_edges_o", 8'h00);
        enter(1'b1, 5);
        pin_count("held_high", 3);
        enter(1'b0, 1);
        pin("after_held", 8'b0000_1000);

        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        pin("mid_reset", 8'h00);
        pin_count("mid_reset_cnt", 0);
        enter_seq(8'b0000_0110, 4);
        pin("reentry", 8'b0000_1000);

        // Strobe held through reset release must not produce an entry.
        @(negedge clk);
        p1 = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        p1 = 1'b0;
        @(negedge clk);
        pin_count("held_thru_reset", 0);

        do_reset();
        b = 4'b0110;
        enter_seq(8'b0001_0110, 5);
        b = 4'b1111;
        enter_seq(8'b0000_0111, 3);
        pin("b_change", 8'b0001_0000);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 79) != 0);
            p0 = ($urandom_range(0, 2) == 0);
            p1 = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 40) == 0) b = 4'($urandom);
        end
        @(negedge clk);
        reset_n = 1'b1;
        p0 = 1'b0;
        p1 = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
